sram_axi_bridge: RTL

//  Converts the two SRAM-like ports (inst, data) from the cache stage into a single AXI3 master port toward the SoC interconnect.

---
 rtl/bridge_pkg.sv | 32 +++
 rtl/sram_axi_bridge.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bridge_pkg.sv
// Shared types and helpers for the SRAM-like to AXI3 bridge.
//   state_t        : bridge FSM states
//   BURST_INCR     : AXI burst encoding used for every transaction
//   SIZE_*         : SRAM-like size encodings
//   size_to_wstrb  : byte-lane strobe for a store of a given size/offset
package bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR_DATA,
        WR_RESP
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Size 3 is treated as a full word.
    function automatic logic [3:0] size_to_wstrb(input logic [1:0] size,
                                                 input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 4'b0001 << addr_lo;
            SIZE_HALF: return 4'b0011 << {addr_lo[1], 1'b0};
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Bridges the cache's two SRAM-like ports (inst, data) onto one AXI3 master.
// One single-beat transaction is in flight at a time; data beats inst.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   inst_* / data_*     : SRAM-like request (req, wr, size, addr, wdata) and
//                         response (rdata, addr_ok, data_ok) per port
//   ar* / r*            : AXI read address / read data channels
//   aw* / w* / b*       : AXI write address / write data / write response
module sram_axi_bridge
    import bridge_pkg::*;
#(
    parameter int ID_W    = 4,
    parameter int INST_ID = 0,
    parameter int DATA_ID = 1
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            inst_req,
    input  logic            inst_wr,
    input  logic [1:0]      inst_size,
    input  logic [31:0]     inst_addr,
    input  logic [31:0]     inst_wdata,
    output logic [31:0]     inst_rdata,
    output logic            inst_addr_ok,
    output logic            inst_data_ok,

    input  logic            data_req,
    input  logic            data_wr,
    input  logic [1:0]      data_size,
    input  logic [31:0]     data_addr,
    input  logic [31:0]     data_wdata,
    output logic [31:0]     data_rdata,
    output logic            data_addr_ok,
    output logic            data_data_ok,

    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [1:0]      arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,

    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,

    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic [1:0]      awlock,
    output logic [3:0]      awcache,
    output logic [2:0]      awprot,
    output logic            awvalid,
    input  logic            awready,

    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,

    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    state_t      state, state_nxt;
    logic        req_port;          // 1 = data port owns the transaction
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        aw_done, w_done;
    logic        aw_fin, w_fin;
    logic        sel_wr;
    logic [ID_W-1:0] req_id;

    // Response IDs/status are not used: only one transaction is ever outstanding.
    logic unused_resp;
    assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

    assign sel_wr = data_req ? data_wr : inst_wr;
    assign aw_fin = aw_done | awready;
    assign w_fin  = w_done  | wready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         if (data_req || inst_req)
                              state_nxt = sel_wr ? WR_ADDR_DATA : RD_ADDR;
            RD_ADDR:      if (arready) state_nxt = RD_DATA;
            RD_DATA:      if (rvalid)  state_nxt = IDLE;
            WR_ADDR_DATA: if (aw_fin && w_fin) state_nxt = WR_RESP;
            WR_RESP:      if (bvalid)  state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    // Request latch and per-channel write handshake tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_port  <= 1'b0;
            req_size  <= 2'd0;
            req_addr  <= 32'd0;
            req_wdata <= 32'd0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            if (state == IDLE && (data_req || inst_req)) begin
                req_port  <= data_req;
                req_size  <= data_req ? data_size  : inst_size;
                req_addr  <= data_req ? data_addr  : inst_addr;
                req_wdata <= data_req ? data_wdata : inst_wdata;
            end
            if (state != WR_ADDR_DATA) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (awready) aw_done <= 1'b1;
                if (wready)  w_done  <= 1'b1;
            end
        end
    end

    always_comb begin
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        data_rdata   = 32'd0;
        case (state)
            IDLE: begin
                // rst gates the grant so nothing is accepted while held in reset.
                data_addr_ok = rst & data_req;
                inst_addr_ok = rst & inst_req & ~data_req;
            end
            RD_ADDR: arvalid = 1'b1;
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    if (req_port) begin
                        data_data_ok = 1'b1;
                        data_rdata   = rdata;
                    end else begin
                        inst_data_ok = 1'b1;
                        inst_rdata   = rdata;
                    end
                end
            end
            WR_ADDR_DATA: begin
                awvalid = ~aw_done;
                wvalid  = ~w_done;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    data_data_ok = req_port;
                    inst_data_ok = ~req_port;
                end
            end
            default: ;
        endcase
    end

    assign req_id  = req_port ? DATA_ID[ID_W-1:0] : INST_ID[ID_W-1:0];

    assign arid    = req_id;
    assign araddr  = req_addr;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, req_size};
    assign arburst = BURST_INCR;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = req_id;
    assign awaddr  = req_addr;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, req_size};
    assign awburst = BURST_INCR;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wid     = req_id;
    assign wdata   = req_wdata;
    assign wstrb   = size_to_wstrb(req_size, req_addr[1:0]);
    assign wlast   = 1'b1;

endmodule
